// File: rtl/pic27_irq_sequencer_if.sv
// Host-side bundle of the interrupt sequencer: config register port plus the
// irq/ack/eoi handshake.
interface pic27_irq_sequencer_if;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [8:0] cfg_wdata;
   logic [8:0] cfg_rdata;
   logic       irq;
   logic [1:0] irq_class;
   logic [3:0] irq_chan;
   logic       irq_ack;
   logic       eoi;
   logic       in_service;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, irq_ack, eoi,
      input  cfg_rdata, irq, irq_class, irq_chan, in_service
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, irq_ack, eoi,
      output cfg_rdata, irq, irq_class, irq_chan, in_service
   );
endinterface

// File: rtl/pic27_irq_sequencer.sv
// Nine-channel, three-class interrupt front-end: captures requests into pending
// registers, arbitrates one winner and runs the irq/ack/eoi handshake with the host.
module pic27_irq_sequencer #(
   parameter int ACK_TIMEOUT = 16,
   parameter int SPUR_W      = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [8:0]                  req_a,
   input  logic [8:0]                  req_b,
   input  logic [8:0]                  req_c,
   pic27_irq_sequencer_if.slave        bus
);

   localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ARB, IRQ, SERVICE} state_t;

   state_t             state;
   logic [8:0]         enable;
   logic [8:0]         level;
   logic [8:0]         pend_a, pend_b, pend_c;
   logic [8:0]         req_prev_a, req_prev_b, req_prev_c;
   logic [SPUR_W-1:0]  spur_cnt;
   logic [TMR_W-1:0]   timer;
   logic               irq_r;
   logic [1:0]         irq_class_r;
   logic [3:0]         irq_chan_r;
   logic               in_service_r;

   logic [8:0]         en_nxt;
   logic [8:0]         set_a, set_b, set_c;
   logic [8:0]         clr_a, clr_b, clr_c;
   logic [8:0]         chan_mask;
   logic [8:0]         pend_any;
   logic [8:0]         live_a, live_b, live_c;
   logic [1:0]         win_class;
   logic [3:0]         win_chan;
   logic               ack_take;
   logic [8:0]         rdata;

   function automatic logic [SPUR_W-1:0] sat_inc(input logic [SPUR_W-1:0] v);
      return (&v) ? v : v + {{(SPUR_W-1){1'b0}}, 1'b1};
   endfunction

   // Highest set index wins within a class.
   function automatic logic [3:0] top_chan(input logic [8:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [8:0] capture(input logic [8:0] req, input logic [8:0] prev,
                                          input logic [8:0] en, input logic [8:0] lvl);
      return en & ((lvl & req) | (~lvl & req & ~prev));
   endfunction

   assign en_nxt   = (bus.cfg_we && bus.cfg_addr == 2'd0) ? bus.cfg_wdata : enable;
   assign set_a    = capture(req_a, req_prev_a, enable, level);
   assign set_b    = capture(req_b, req_prev_b, enable, level);
   assign set_c    = capture(req_c, req_prev_c, enable, level);
   assign pend_any = pend_a | pend_b | pend_c;

   assign ack_take  = (state == IRQ) && bus.irq_ack;
   assign chan_mask = 9'd1 << irq_chan_r;
   assign clr_a     = (ack_take && irq_class_r == 2'd1) ? chan_mask : 9'd0;
   assign clr_b     = (ack_take && irq_class_r == 2'd2) ? chan_mask : 9'd0;
   assign clr_c     = (ack_take && irq_class_r == 2'd3) ? chan_mask : 9'd0;

   // A disable write landing in the ARB cycle must not let a dead channel win.
   assign live_a = pend_a & en_nxt;
   assign live_b = pend_b & en_nxt;
   assign live_c = pend_c & en_nxt;

   always_comb begin
      win_class = 2'd0;
      win_chan  = 4'd0;
      if (|live_a) begin
         win_class = 2'd1;
         win_chan  = top_chan(live_a);
      end else if (|live_b) begin
         win_class = 2'd2;
         win_chan  = top_chan(live_b);
      end else if (|live_c) begin
         win_class = 2'd3;
         win_chan  = top_chan(live_c);
      end
   end

   always_comb begin
      rdata = 9'd0;
      case (bus.cfg_addr)
         2'd0:    rdata = enable;
         2'd1:    rdata = level;
         2'd2:    rdata = pend_any;
         default: rdata = 9'(spur_cnt);
      endcase
   end

   assign bus.cfg_rdata  = rdata;
   assign bus.irq        = irq_r;
   assign bus.irq_class  = irq_class_r;
   assign bus.irq_chan   = irq_chan_r;
   assign bus.in_service = in_service_r;

   // Config, capture and pending state; a new set outranks the ack clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable     <= 9'd0;
         level      <= 9'd0;
         pend_a     <= 9'd0;
         pend_b     <= 9'd0;
         pend_c     <= 9'd0;
         req_prev_a <= 9'd0;
         req_prev_b <= 9'd0;
         req_prev_c <= 9'd0;
      end else begin
         enable <= en_nxt;
         if (bus.cfg_we && bus.cfg_addr == 2'd1) level <= bus.cfg_wdata;
         pend_a     <= ((pend_a & ~clr_a) | set_a) & en_nxt;
         pend_b     <= ((pend_b & ~clr_b) | set_b) & en_nxt;
         pend_c     <= ((pend_c & ~clr_c) | set_c) & en_nxt;
         req_prev_a <= req_a;
         req_prev_b <= req_b;
         req_prev_c <= req_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         irq_r        <= 1'b0;
         irq_class_r  <= 2'd0;
         irq_chan_r   <= 4'd0;
         in_service_r <= 1'b0;
         timer        <= '0;
         spur_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|pend_any) state <= ARB;
            end
            ARB: begin
               if (win_class == 2'd0) begin
                  state <= IDLE;
               end else begin
                  irq_class_r <= win_class;
                  irq_chan_r  <= win_chan;
                  irq_r       <= 1'b1;
                  timer       <= '0;
                  state       <= IRQ;
               end
            end
            IRQ: begin
               // Ack outranks both withdrawal causes, including a same-cycle timeout.
               if (bus.irq_ack) begin
                  irq_r        <= 1'b0;
                  in_service_r <= 1'b1;
                  state        <= SERVICE;
               end else if (!en_nxt[irq_chan_r]) begin
                  irq_r       <= 1'b0;
                  irq_class_r <= 2'd0;
                  irq_chan_r  <= 4'd0;
                  state       <= IDLE;
               end else if (timer == TMR_MAX) begin
                  irq_r       <= 1'b0;
                  irq_class_r <= 2'd0;
                  irq_chan_r  <= 4'd0;
                  spur_cnt    <= sat_inc(spur_cnt);
                  state       <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            SERVICE: begin
               if (bus.eoi) begin
                  in_service_r <= 1'b0;
                  irq_class_r  <= 2'd0;
                  irq_chan_r   <= 4'd0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
